// File: rtl/phase_gen_if.sv
// Configuration, control and phase-sample signals of the phase generator.
// The slave side is the generator; the master side drives config and consumes samples.
interface phase_gen_if #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
);
  logic             cfg_we;
  logic [ACC_W-1:0] cfg_freq;
  logic [ACC_W-1:0] cfg_step;
  logic [CNT_W-1:0] cfg_len;
  logic [15:0]      cfg_offset;
  logic             start;
  logic             stop;
  logic [15:0]      source;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (
    output cfg_we, cfg_freq, cfg_step, cfg_len, cfg_offset, start, stop,
    input  source, valid, busy, done
  );

  modport slave (
    input  cfg_we, cfg_freq, cfg_step, cfg_len, cfg_offset, start, stop,
    output source, valid, busy, done
  );
endinterface

// File: rtl/phase_gen.sv
// Chirp-capable phase accumulator emitting bounded bursts of Q1.15 phase words,
// one per clock, for the downstream cosine stage.
//
// state  | meaning
// IDLE   | waiting for start; config writes accepted
// RUN    | emitting one sample per clock until the count expires or stop
// DONE   | one-cycle done pulse, then back to IDLE
module phase_gen #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  phase_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] freq_q, freq_d;
  logic [ACC_W-1:0] step_q, step_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [15:0]      off_q, off_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] fcw_q, fcw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      source_q, source_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      freq_q   <= '0;
      step_q   <= '0;
      len_q    <= '0;
      off_q    <= '0;
      acc_q    <= '0;
      fcw_q    <= '0;
      cnt_q    <= '0;
      source_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      freq_q   <= freq_d;
      step_q   <= step_d;
      len_q    <= len_d;
      off_q    <= off_d;
      acc_q    <= acc_d;
      fcw_q    <= fcw_d;
      cnt_q    <= cnt_d;
      source_q <= source_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    freq_d   = freq_q;
    step_d   = step_q;
    len_d    = len_q;
    off_d    = off_q;
    acc_d    = acc_q;
    fcw_d    = fcw_q;
    cnt_d    = cnt_q;
    source_d = source_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cfg_we) begin
          freq_d = bus.cfg_freq;
          step_d = bus.cfg_step;
          len_d  = bus.cfg_len;
          off_d  = bus.cfg_offset;
        end
        // A same-cycle config write does not affect this start: it uses the _q values.
        if (bus.start && !bus.stop) begin
          if (len_q != '0) begin
            state_d = S_RUN;
            acc_d   = '0;
            fcw_d   = freq_q;
            cnt_d   = len_q;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else begin
          source_d = acc_q[ACC_W-1 -: 16] + off_q;
          valid_d  = 1'b1;
          acc_d    = acc_q + fcw_q;
          fcw_d    = fcw_q + step_q;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.source = source_q;
  assign bus.valid  = valid_q;
  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = done_q;

endmodule

// File: tb/tb_phase_gen.sv
// Directed bench for phase_gen: expected samples are queued by the stimulus and
// consumed by a monitor whenever valid is seen; status timing is checked inline.
module tb_phase_gen;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   done_exp = 0;
  int   done_seen = 0;
  logic [15:0] exp_q[$];

  phase_gen_if #(.ACC_W(32), .CNT_W(16)) bus ();

  phase_gen #(.ACC_W(32), .CNT_W(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic status(input string name, input logic b, input logic v, input logic d);
    chk({name, ".busy"}, {31'd0, bus.busy}, {31'd0, b});
    chk({name, ".valid"}, {31'd0, bus.valid}, {31'd0, v});
    chk({name, ".done"}, {31'd0, bus.done}, {31'd0, d});
  endtask

  task automatic cfg(input logic [31:0] f, input logic [31:0] s, input logic [15:0] l,
                     input logic [15:0] o);
    bus.cfg_we = 1'b1;
    bus.cfg_freq = f;
    bus.cfg_step = s;
    bus.cfg_len = l;
    bus.cfg_offset = o;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  // Full burst of len samples with per-cycle status checks; expected samples pushed by caller.
  task automatic burst(input string name, input int len);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    status({name, ".t1"}, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < len; i++) begin
      tick();
      status({name, ".run"}, 1'b1, 1'b1, 1'b0);
    end
    tick();
    status({name, ".done"}, 1'b0, 1'b0, 1'b1);
    done_exp++;
    tick();
    status({name, ".after"}, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compares every presented sample against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.done) done_seen++;
      if (bus.valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_sample", {16'd0, bus.source}, 32'hFFFF_FFFF);
        end else begin
          chk("sample", {16'd0, bus.source}, {16'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.cfg_we = 1'b0;
    bus.cfg_freq = '0;
    bus.cfg_step = '0;
    bus.cfg_len = '0;
    bus.cfg_offset = '0;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    status("reset", 1'b0, 1'b0, 1'b0);
    chk("reset.source", {16'd0, bus.source}, 32'h0);
    reset = 1'b1;
    tick();

    // Linear ramp
    cfg(32'h1000_0000, 32'h0, 16'd4, 16'h0);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h1000);
    exp_q.push_back(16'h2000); exp_q.push_back(16'h3000);
    burst("ramp", 4);

    // Wrap in both accumulator and offset add
    cfg(32'h4000_0000, 32'h0, 16'd5, 16'h8000);
    exp_q.push_back(16'h8000); exp_q.push_back(16'hC000); exp_q.push_back(16'h0000);
    exp_q.push_back(16'h4000); exp_q.push_back(16'h8000);
    burst("wrap", 5);

    // Positive and negative chirp
    cfg(32'h0, 32'h0100_0000, 16'd4, 16'h0);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0100); exp_q.push_back(16'h0300);
    burst("chirp_up", 4);
    cfg(32'h0, 32'hFF00_0000, 16'd4, 16'h0);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    exp_q.push_back(16'hFF00); exp_q.push_back(16'hFD00);
    burst("chirp_dn", 4);

    // Stop mid-burst: three samples, then idle with no done
    cfg(32'h0200_0000, 32'h0, 16'd10, 16'h0);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0200); exp_q.push_back(16'h0400);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("stop.last", {16'd0, bus.source}, 32'h0400);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    status("stop.s1", 1'b0, 1'b0, 1'b0);
    tick();
    status("stop.s2", 1'b0, 1'b0, 1'b0);
    chk("stop.hold", {16'd0, bus.source}, 32'h0400);
    for (int i = 0; i < 10; i++) exp_q.push_back(16'(i * 16'h0200));
    burst("restart", 10);

    // Zero-length burst
    cfg(32'h0200_0000, 32'h0, 16'd0, 16'h0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    status("len0.t1", 1'b1, 1'b0, 1'b0);
    tick();
    status("len0.t2", 1'b0, 1'b0, 1'b1);
    done_exp++;

    // start + cfg_we during a running burst are ignored
    cfg(32'h1000_0000, 32'h0, 16'd4, 16'h0);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h1000);
    exp_q.push_back(16'h2000); exp_q.push_back(16'h3000);
    bus.start = 1'b1;
    tick();
    bus.cfg_we = 1'b1;
    bus.cfg_freq = 32'h0800_0000;
    bus.cfg_len = 16'd3;
    tick();
    bus.cfg_we = 1'b0;
    bus.start = 1'b0;
    status("ign.run1", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    status("ign.run4", 1'b1, 1'b1, 1'b0);
    tick();
    status("ign.done", 1'b0, 1'b0, 1'b1);
    done_exp++;
    tick();
    exp_q.push_back(16'h0000); exp_q.push_back(16'h1000);
    exp_q.push_back(16'h2000); exp_q.push_back(16'h3000);
    burst("ign.next", 4);

    // Reset held two cycles mid-burst clears everything, config included
    cfg(32'h1000_0000, 32'h0, 16'd10, 16'h0);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h1000);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    status("rst_mid", 1'b0, 1'b0, 1'b0);
    chk("rst_mid.source", {16'd0, bus.source}, 32'h0);
    tick();
    status("rst_mid.hold", 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    status("rst_len0.t1", 1'b1, 1'b0, 1'b0);
    tick();
    status("rst_len0.t2", 1'b0, 1'b0, 1'b1);
    done_exp++;

    tick();
    tick();
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("done_count", done_seen, done_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
